// File: rtl/if_fetch_response_aligner.sv
// Pairs one-cycle-late SRAM read data with the PC that requested it and holds the bundle over stalls.
// Optional FETCH_MISALIGN_CHK_EN adds misalign_o and kills fetches whose PC is not word aligned.
module if_fetch_response_aligner #(
    parameter int unsigned            PC_WIDTH   = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0]  NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [PC_WIDTH-1:0]   req_pc_i,
    input  logic                  req_valid_i,
    input  logic [INST_WIDTH-1:0] sram_rdata_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [PC_WIDTH-1:0]   inst_pc_o,
    output logic                  inst_valid_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic                  misalign_o
`endif
);

    typedef enum logic [0:0] {StLive, StHeld} state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
    logic [PC_WIDTH-1:0]   hold_pc_q, hold_pc_d;
    logic                  hold_valid_q, hold_valid_d;

    logic [INST_WIDTH-1:0] live_inst;
    logic [INST_WIDTH-1:0] sel_inst;
    logic [PC_WIDTH-1:0]   sel_pc;
    logic                  sel_valid;
    logic                  kill;

    assign live_inst = pend_valid_q ? sram_rdata_i : NOP_INST;

    always_comb begin
        if (state_q == StHeld) begin
            sel_inst  = hold_inst_q;
            sel_pc    = hold_pc_q;
            sel_valid = hold_valid_q;
        end else begin
            sel_inst  = live_inst;
            sel_pc    = pend_pc_q;
            sel_valid = pend_valid_q;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign;
    assign misalign   = sel_valid & (sel_pc[1:0] != 2'b00) & ~flush_i;
    assign misalign_o = misalign;
    assign kill       = flush_i | misalign;
`else
    assign kill       = flush_i;
`endif

    always_comb begin
        inst_o       = kill ? NOP_INST : sel_inst;
        inst_pc_o    = sel_pc;
        inst_valid_o = sel_valid & ~kill;
    end

    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;
        if (flush_i) begin
            // The request presented alongside a flush is on the wrong path and is dropped.
            pend_valid_d = 1'b0;
            hold_valid_d = 1'b0;
            state_d      = StLive;
        end else if (stall_i) begin
            if (state_q == StLive) begin
                hold_inst_d  = live_inst;
                hold_pc_d    = pend_pc_q;
                hold_valid_d = pend_valid_q;
                state_d      = StHeld;
            end
        end else begin
            pend_pc_d    = req_pc_i;
            pend_valid_d = req_valid_i;
            state_d      = StLive;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StLive;
            pend_pc_q    <= '0;
            pend_valid_q <= 1'b0;
            hold_inst_q  <= NOP_INST;
            hold_pc_q    <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_response_aligner.sv
// Randomized bench for if_fetch_response_aligner against a transaction-level reference model.
module tb_if_fetch_response_aligner;

    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } bundle_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] req_pc_i = '0;
    logic        req_valid_i = 1'b0;
    logic [31:0] sram_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int failures = 0;

    // Model state: last accepted request, and the bundle frozen by an ongoing stall.
    bundle_t req_m;
    bundle_t frozen_b;
    bit      frozen_m;

    always #5 clk_i = ~clk_i;

    if_fetch_response_aligner dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .req_pc_i     (req_pc_i),
        .req_valid_i  (req_valid_i),
        .sram_rdata_i (sram_rdata_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        req_m.inst  = Nop;
        req_m.pc    = '0;
        req_m.valid = 1'b0;
        frozen_m    = 1'b0;
        frozen_b    = req_m;
    endtask

    // One clock cycle: drive, check settled outputs, then advance the model at the edge.
    task automatic step(input bit rst, input bit stall, input bit flush, input bit rv,
                        input logic [31:0] pc, input logic [31:0] rdata);
        bundle_t     pre;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_mis;
        @(negedge clk_i);
        rst_i        = rst;
        stall_i      = stall;
        flush_i      = flush;
        req_valid_i  = rv;
        req_pc_i     = pc;
        sram_rdata_i = rdata;
        #1;
        if (frozen_m) begin
            pre = frozen_b;
        end else begin
            pre.inst  = req_m.valid ? rdata : Nop;
            pre.pc    = req_m.pc;
            pre.valid = req_m.valid;
        end
        e_mis = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        e_mis = pre.valid && (pre.pc % 4 != 0) && !flush;
        check("misalign", 32'(misalign_o), 32'(e_mis));
`endif
        e_valid = pre.valid && !flush && !e_mis;
        e_inst  = (flush || e_mis) ? Nop : pre.inst;
        check("inst", inst_o, e_inst);
        check("pc", inst_pc_o, pre.pc);
        check("valid", 32'(inst_valid_o), 32'(e_valid));
        @(posedge clk_i);
        if (rst) begin
            model_reset();
        end else if (flush) begin
            req_m.valid = 1'b0;
            frozen_m    = 1'b0;
        end else if (stall) begin
            if (!frozen_m) begin
                frozen_b = pre;
                frozen_m = 1'b1;
            end
        end else begin
            req_m.pc    = pc;
            req_m.valid = rv;
            frozen_m    = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_inst", inst_o, Nop);
        check("rst_pc", inst_pc_o, 32'h0);
        check("rst_valid", 32'(inst_valid_o), 32'h0);

        // Streaming 0x0, 0x4, 0x8, then a 3-cycle stall while 0x8 is on the outputs.
        step(0, 0, 0, 1, 32'h0, 32'h1111_1111);
        step(0, 0, 0, 1, 32'h4, 32'h0050_0093);
        step(0, 0, 0, 1, 32'h8, 32'h0010_0113);
        step(0, 1, 0, 1, 32'hC, 32'h0020_81B3);
        step(0, 1, 0, 1, 32'hC, 32'hDEAD_BEEF);
        step(0, 1, 0, 1, 32'hC, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 32'hC, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 32'h10, 32'h0000_0C0C);
        // Flush with 0x10 pending, then a new request at 0x40.
        step(0, 0, 1, 1, 32'h14, 32'h0000_1010);
        step(0, 0, 0, 1, 32'h40, 32'h0000_BAD0);
        step(0, 0, 0, 1, 32'h44, 32'h0000_4040);
        // Stall and flush together, then flush while held.
        step(0, 1, 1, 1, 32'h48, 32'h0000_4444);
        step(0, 0, 0, 1, 32'h80, 32'h0000_5555);
        step(0, 1, 0, 1, 32'h84, 32'h0000_8080);
        step(0, 1, 0, 1, 32'h84, 32'h0000_6666);
        step(0, 1, 1, 1, 32'h84, 32'h0000_7777);
        step(0, 0, 0, 0, 32'h88, 32'h0000_8888);
        step(0, 0, 0, 1, 32'h90, 32'h0000_9999);
        // Reset mid-held discards the bundle.
        step(0, 1, 0, 1, 32'h94, 32'h0000_9090);
        step(0, 1, 0, 1, 32'h94, 32'h0000_AAAA);
        step(1, 1, 0, 1, 32'h94, 32'h0000_BBBB);
        step(0, 0, 0, 1, 32'h6, 32'h0000_CCCC);
        // Misaligned PC: killed only when the check is built in.
        step(0, 0, 0, 1, 32'h8, 32'h0000_0606);
        step(0, 0, 0, 0, 32'h0, 32'h0000_0808);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(9) == 0) pc[1:0] = 2'($urandom_range(3));
            step($urandom_range(29) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
                 $urandom_range(4) != 0, pc, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
